// File: rtl/coef_sweep_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// coef_sweep_sequencer_pkg
//   Shared definitions for the coefficient sweep sequencer. It holds the FSM
//   state encoding, the coefficient-select counter width and its three
//   landmark values:
//     CNTR_IDLE  - zero coefficients selected, no sweep
//     CNTR_FIRST - first coefficient set of a sweep
//     CNTR_LAST  - last coefficient set of a sweep
// -----------------------------------------------------------------------------
package coef_sweep_sequencer_pkg;

    localparam int CNTR_W = 3;

    localparam logic [CNTR_W-1:0] CNTR_IDLE  = 3'd0;
    localparam logic [CNTR_W-1:0] CNTR_FIRST = 3'd1;
    localparam logic [CNTR_W-1:0] CNTR_LAST  = 3'd6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

endpackage : coef_sweep_sequencer_pkg

// File: rtl/coef_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// coef_sweep_sequencer
//   Accepts a signed sample triplet over a valid/ready handshake, holds it on
//   dp_d0..dp_d2 and steps the datapath coefficient select dp_cntr through
//   1..6. A new triplet may be taken on the cycle dp_cntr is 6, so sweeps can
//   run back to back with no gap. out_valid/out_idx/out_last trail dp_cntr by
//   one cycle so that they line up with the datapath's output register.
//
// Parameters
//   PD, P        integer / fractional bits of a sample (PDQP, PD+P bits wide)
//
// Ports
//   clk          clock, all state changes on its rising edge
//   rst          synchronous reset, active-high
//   in_valid     triplet offered on in_d0..in_d2
//   in_ready     triplet accepted this cycle (0 while rst is high)
//   in_d0..in_d2 incoming sample triplet
//   dp_d0..dp_d2 held triplet to the datapath
//   dp_cntr      coefficient select (0 = zero coefficients, 1..6 = sets)
//   busy         a sweep is in progress
//   out_valid    datapath registered outputs valid this cycle
//   out_idx      coefficient index (1..6) of those outputs
//   out_last     out_valid with out_idx == 6
//   frame_cnt    completed-sweep count, 16 bits, wraps; present only when
//                COEF_SWEEP_FRAME_CNT_EN is defined
// -----------------------------------------------------------------------------
module coef_sweep_sequencer
    import coef_sweep_sequencer_pkg::*;
#(
    parameter int PD = 4,
    parameter int P  = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PD+P-1:0]   in_d0,
    input  logic signed [PD+P-1:0]   in_d1,
    input  logic signed [PD+P-1:0]   in_d2,
    output logic signed [PD+P-1:0]   dp_d0,
    output logic signed [PD+P-1:0]   dp_d1,
    output logic signed [PD+P-1:0]   dp_d2,
    output logic [CNTR_W-1:0]        dp_cntr,
    output logic                     busy,
    output logic                     out_valid,
    output logic [CNTR_W-1:0]        out_idx,
`ifdef COEF_SWEEP_FRAME_CNT_EN
    output logic                     out_last,
    output logic [15:0]              frame_cnt
`else
    output logic                     out_last
`endif
);

    localparam int W = PD + P;

    state_e                state_q, state_d;
    logic [CNTR_W-1:0]     cntr_q, cntr_d;
    logic signed [W-1:0]   d0_q, d0_d;
    logic signed [W-1:0]   d1_q, d1_d;
    logic signed [W-1:0]   d2_q, d2_d;
    logic                  out_valid_q, out_valid_d;
    logic [CNTR_W-1:0]     out_idx_q, out_idx_d;
    logic                  out_last_q, out_last_d;

    logic                  can_accept;
    logic                  accept;

    // Ready depends only on registered state (and reset), never on in_valid.
    // cntr_q reaches CNTR_LAST only while sweeping, so no state term is needed.
    assign can_accept = (state_q == ST_IDLE) || (cntr_q == CNTR_LAST);
    assign accept     = in_valid && can_accept;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        cntr_d  = cntr_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        d2_d    = d2_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SWEEP;
                    cntr_d  = CNTR_FIRST;
                end
            end
            ST_SWEEP: begin
                if (cntr_q != CNTR_LAST) begin
                    cntr_d = cntr_q + CNTR_W'(1);
                end else if (accept) begin
                    // Back-to-back sweep: restart with the new triplet.
                    cntr_d = CNTR_FIRST;
                end else begin
                    state_d = ST_IDLE;
                    cntr_d  = CNTR_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cntr_d  = CNTR_IDLE;
            end
        endcase

        if (accept) begin
            d0_d = in_d0;
            d1_d = in_d1;
            d2_d = in_d2;
        end

        // Mirror of the datapath output register: tags follow dp_cntr by one.
        out_valid_d = (state_q == ST_SWEEP);
        out_idx_d   = cntr_q;
        out_last_d  = (cntr_q == CNTR_LAST);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (rst) begin
            state_q     <= ST_IDLE;
            cntr_q      <= CNTR_IDLE;
            d0_q        <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= CNTR_IDLE;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cntr_q      <= cntr_d;
            d0_q        <= d0_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef COEF_SWEEP_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Counts each out_last pulse; natural 16-bit wrap from 0xFFFF to 0.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (out_last_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign in_ready  = !rst && can_accept;
    assign busy      = (state_q == ST_SWEEP);
    assign dp_cntr   = cntr_q;
    assign dp_d0     = d0_q;
    assign dp_d1     = d1_q;
    assign dp_d2     = d2_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule : coef_sweep_sequencer

// File: tb/tb_coef_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// tb_coef_sweep_sequencer
//   Directed and randomized stimulus for coef_sweep_sequencer. The reference
//   model is a timeline: accepting a triplet in cycle c books coefficient
//   selects 1..6 into cycles c+1..c+6; the output tags are that timeline read
//   one cycle late. Reset wipes the booked future.
//   frame_cnt is checked when COEF_SWEEP_FRAME_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_coef_sweep_sequencer;

    localparam int PD   = 4;
    localparam int P    = 9;
    localparam int W    = PD + P;
    localparam int MAXC = 4096;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  in_d0, in_d1, in_d2;
    logic signed [W-1:0]  dp_d0, dp_d1, dp_d2;
    logic [2:0]           dp_cntr;
    logic                 busy;
    logic                 out_valid;
    logic [2:0]           out_idx;
    logic                 out_last;
`ifdef COEF_SWEEP_FRAME_CNT_EN
    logic [15:0]          frame_cnt;
    int                   m_frames;
`endif

    int checks   = 0;
    int failures = 0;

    coef_sweep_sequencer #(.PD(PD), .P(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_d0     (in_d0),
        .in_d1     (in_d1),
        .in_d2     (in_d2),
        .dp_d0     (dp_d0),
        .dp_d1     (dp_d1),
        .dp_d2     (dp_d2),
        .dp_cntr   (dp_cntr),
        .busy      (busy),
        .out_valid (out_valid),
        .out_idx   (out_idx),
`ifdef COEF_SWEEP_FRAME_CNT_EN
        .out_last  (out_last),
        .frame_cnt (frame_cnt)
`else
        .out_last  (out_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference timeline.
    int                   exp_cntr [MAXC];
    bit                   rst_edge [MAXC];
    int                   sched_end = -100;
    int                   cyc = 0;
    logic signed [W-1:0]  m_d0 = '0, m_d1 = '0, m_d2 = '0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check in_ready, advance the model and
    // the clock, then check every registered output.
    task automatic step(input logic r, input logic v,
                        input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                        input logic signed [W-1:0] c, output logic acc);
        logic exp_ready;
        int   prev;
        rst      = r;
        in_valid = v;
        in_d0    = a;
        in_d1    = b;
        in_d2    = c;
        #1;
        // Ready when idle (past the booked sweep) or on its final cycle.
        exp_ready = !r && (cyc >= sched_end);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = v && exp_ready;

`ifdef COEF_SWEEP_FRAME_CNT_EN
        if (r) m_frames = 0;
        else if (!rst_edge[cyc] && cyc > 0 && exp_cntr[cyc-1] == 6)
            m_frames = (m_frames + 1) % 65536;
`endif
        if (r) begin
            for (int k = 1; k <= 6; k++) exp_cntr[cyc+k] = 0;
            sched_end      = -100;
            m_d0           = '0;
            m_d1           = '0;
            m_d2           = '0;
            rst_edge[cyc+1] = 1'b1;
        end else if (acc) begin
            for (int k = 1; k <= 6; k++) exp_cntr[cyc+k] = k;
            sched_end = cyc + 6;
            m_d0      = a;
            m_d1      = b;
            m_d2      = c;
        end

        @(posedge clk);
        #1;
        cyc++;

        prev = rst_edge[cyc] ? 0 : exp_cntr[cyc-1];
        check("dp_cntr",   32'(dp_cntr),   32'(exp_cntr[cyc]));
        check("busy",      32'(busy),      32'(exp_cntr[cyc] != 0));
        check("out_valid", 32'(out_valid), 32'(prev != 0));
        check("out_idx",   32'(out_idx),   32'(prev));
        check("out_last",  32'(out_last),  32'(prev == 6));
        check("dp_d0",     32'(dp_d0),     32'(m_d0));
        check("dp_d1",     32'(dp_d1),     32'(m_d1));
        check("dp_d2",     32'(dp_d2),     32'(m_d2));
`ifdef COEF_SWEEP_FRAME_CNT_EN
        check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
`endif
    endtask

    initial begin
        logic                acc;
        logic                hold_v;
        logic signed [W-1:0] ha, hb, hc;
        int                  n_acc;
        int                  ov_run;

        rst = 1'b1; in_valid = 1'b0; in_d0 = '0; in_d1 = '0; in_d2 = '0;
`ifdef COEF_SWEEP_FRAME_CNT_EN
        m_frames = 0;
`endif

        // Reset, then a single triplet 1,2,3 followed by idle.
        step(1, 0, 0, 0, 0, acc);
        step(1, 1, 5, 5, 5, acc);
        step(0, 1, 13'sd1, 13'sd2, 13'sd3, acc);
        check("first_accept", 32'(acc), 32'(1));
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, acc);
        check("idle_after_sweep", 32'(dp_cntr), 32'(0));
        check("held_d1_after_sweep", 32'(dp_d1), 32'(2));

        // Three triplets with in_valid held high: count out_valid run length.
        n_acc  = 0;
        ov_run = 0;
        ha = 13'sh100; hb = -13'sd7; hc = 13'sd42;
        for (int i = 0; i < 24 && n_acc < 3; i++) begin
            step(0, 1, ha, hb, hc, acc);
            if (acc) begin
                n_acc++;
                ha = ha + 13'sd11; hb = hb - 13'sd3; hc = hc ^ 13'sh0f0;
            end
        end
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0, acc);
            if (out_valid) ov_run++;
        end
        check("b2b_accepts", 32'(n_acc), 32'(3));
        // The final accepted triplet's sweep plays out during the idle tail;
        // earlier cycles were checked cycle by cycle against the timeline.
        check("b2b_tail_outvalid", 32'(ov_run), 32'(6));

        // in_valid pulsed while dp_cntr == 3 must be ignored.
        step(0, 1, 13'sd100, 13'sd200, 13'sd300, acc);
        step(0, 0, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, acc);
        check("cntr_is_3", 32'(dp_cntr), 32'(3));
        step(0, 1, -13'sd1, -13'sd1, -13'sd1, acc);
        check("ignored_accept", 32'(acc), 32'(0));
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, acc);

        // Reset while dp_cntr == 4, then a fresh triplet.
        step(0, 1, 13'sd9, 13'sd8, 13'sd7, acc);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, acc);
        check("cntr_is_4", 32'(dp_cntr), 32'(4));
        step(1, 0, 0, 0, 0, acc);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, acc);
        step(0, 1, 13'sd4, 13'sd5, 13'sd6, acc);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, acc);

        // Randomized traffic: the source holds a triplet until it is taken.
        hold_v = 1'b0;
        ha = '0; hb = '0; hc = '0;
        for (int i = 0; i < 800; i++) begin
            if (!hold_v && ($urandom_range(0, 3) != 0)) begin
                hold_v = 1'b1;
                ha = W'($urandom);
                hb = W'($urandom);
                hc = W'($urandom);
            end
            if ($urandom_range(0, 79) == 0) begin
                step(1, hold_v, ha, hb, hc, acc);
                hold_v = 1'b0;
            end else begin
                step(0, hold_v, ha, hb, hc, acc);
                if (acc) hold_v = 1'b0;
            end
        end
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_coef_sweep_sequencer
